// File: rtl/inverse_lifting_unit_1d.sv
// rtl/inverse_lifting_unit_1d.sv - inverse 9/7 lifting update/predict pair on a row stream of {d, s} pairs
// Optional INV_LIFT_SATURATE_EN: both subtractions saturate instead of wrapping.
module inverse_lifting_unit_1d #(
  parameter int  DataWidth = 16,
  parameter int  Point     = 10,
  parameter real Alpha     = -1.586134342,
  parameter real Beta      = -0.052980118
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [2*DataWidth-1:0] s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
);
  localparam int CoefAInt = $rtoi(Alpha * $itor(1 << Point));
  localparam int CoefBInt = $rtoi(Beta * $itor(1 << Point));
  localparam logic signed [DataWidth:0] CoefA = (DataWidth+1)'(CoefAInt);
  localparam logic signed [DataWidth:0] CoefB = (DataWidth+1)'(CoefBInt);

  function automatic logic [DataWidth:0] add_ext(input logic [DataWidth-1:0] a,
                                                 input logic [DataWidth-1:0] b);
    return {a[DataWidth-1], a} + {b[DataWidth-1], b};
  endfunction

  // Full-width signed product, floor shift by Point, keep the low DataWidth bits.
  function automatic logic [DataWidth-1:0] mul_shift(input logic signed [DataWidth:0] k,
                                                     input logic signed [DataWidth:0] x);
    logic signed [2*DataWidth+1:0] p;
    p = (2*DataWidth+2)'(k) * (2*DataWidth+2)'(x);
    p = p >>> Point;
    return p[DataWidth-1:0];
  endfunction

  function automatic logic [DataWidth-1:0] sub_op(input logic [DataWidth-1:0] a,
                                                  input logic [DataWidth-1:0] b);
    logic [DataWidth:0] diff;
    diff = {a[DataWidth-1], a} - {b[DataWidth-1], b};
`ifdef INV_LIFT_SATURATE_EN
    if (diff[DataWidth] != diff[DataWidth-1])
      return {diff[DataWidth], {(DataWidth-1){~diff[DataWidth]}}};
`endif
    return diff[DataWidth-1:0];
  endfunction

  logic                 first_q;
  logic                 r0_valid, r0_sof, r0_eol;
  logic [DataWidth-1:0] r0_d, r0_s, d_prev;
  logic                 r1_valid, r1_sof, r1_eol;
  logic [DataWidth-1:0] r1_d, r1_even;
  logic                 h_valid, h_sof, h_eol;
  logic [DataWidth-1:0] h_d, h_even;

  logic r2_ld, h_go, h_ld, r1_go, r1_ld, r0_go, accept;
  logic [DataWidth-1:0] d_left, even_new, even_right, odd_new;

  // H only releases once its right-hand even neighbour exists (R1) or it ends the line.
  assign r2_ld     = !m_valid_o || m_ready_i;
  assign h_go      = h_valid && (h_eol || r1_valid) && r2_ld;
  assign h_ld      = !h_valid || h_go;
  assign r1_go     = r1_valid && h_ld;
  assign r1_ld     = !r1_valid || r1_go;
  assign r0_go     = r0_valid && r1_ld;
  assign s_ready_o = !r0_valid || r0_go;
  assign accept    = s_valid_i && s_ready_o;

  assign d_left     = r0_sof ? r0_d : d_prev;
  assign even_new   = sub_op(r0_s, mul_shift(CoefB, add_ext(r0_d, d_left)));
  assign even_right = h_eol ? h_even : r1_even;
  assign odd_new    = sub_op(h_d, mul_shift(CoefA, add_ext(h_even, even_right)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      first_q   <= 1'b1;
      r0_valid  <= 1'b0;
      r1_valid  <= 1'b0;
      h_valid   <= 1'b0;
      d_prev    <= '0;
      m_valid_o <= 1'b0;
      m_sof_o   <= 1'b0;
      m_eol_o   <= 1'b0;
      m_data_o  <= '0;
    end else begin
      if (s_ready_o) begin
        r0_valid <= s_valid_i;
        if (s_valid_i) begin
          r0_sof <= s_sof_i || first_q;
          r0_eol <= s_eol_i;
          r0_d   <= s_data_i[2*DataWidth-1:DataWidth];
          r0_s   <= s_data_i[DataWidth-1:0];
        end
      end
      if (accept) first_q <= 1'b0;

      if (r1_ld) r1_valid <= r0_valid;
      if (r0_go) begin
        r1_sof  <= r0_sof;
        r1_eol  <= r0_eol;
        r1_d    <= r0_d;
        r1_even <= even_new;
        d_prev  <= r0_d;
      end

      if (h_ld) h_valid <= r1_valid;
      if (r1_go) begin
        h_sof  <= r1_sof;
        h_eol  <= r1_eol;
        h_d    <= r1_d;
        h_even <= r1_even;
      end

      if (r2_ld) begin
        m_valid_o <= h_go;
        if (h_go) begin
          m_sof_o  <= h_sof;
          m_eol_o  <= h_eol;
          m_data_o <= {odd_new, h_even};
        end
      end
    end
  end
endmodule
